// File: rtl/jk_mod_counter_if.sv
// Control/data bundle between a jk_mod_counter stage and whatever drives it.
// The driver side loads, enables and steers the counter; the counter returns Q, CO and ILL.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             LD;
  logic             EP;
  logic             ET;
  logic             UD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             CO;
  logic             ILL;

  modport master (
    output LD, EP, ET, UD, D,
    input  Q, CO, ILL
  );

  modport slave (
    input  LD, EP, ET, UD, D,
    output Q, CO, ILL
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from per-bit JK next-state logic, with
// parallel load, cascade enables, terminal count and self-starting recovery.
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic              CP,
  input  logic              CR,
  jk_mod_counter_if.slave   bus
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    M_HOLD    = 2'd0,
    M_LOAD    = 2'd1,
    M_COUNT   = 2'd2,
    M_RECOVER = 2'd3
  } jk_mode_e;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] recover_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] q_next_s;
  logic             ill_s;
  logic             at_last_s;
  logic             at_zero_s;
  logic             co_s;
  jk_mode_e         mode_s;

  // Binary increment: bit i toggles when every lower bit is 1.
  function automatic logic [WIDTH-1:0] up_toggle(input logic [WIDTH-1:0] q);
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_toggle[i] = carry;
      carry        = carry & q[i];
    end
  endfunction

  // Binary decrement: bit i toggles when every lower bit is 0.
  function automatic logic [WIDTH-1:0] down_toggle(input logic [WIDTH-1:0] q);
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      down_toggle[i] = borrow;
      borrow         = borrow & ~q[i];
    end
  endfunction

  assign ill_s     = ({1'b0, q_r} >= MOD_EXT);
  assign at_last_s = (q_r == LAST);
  assign at_zero_s = (q_r == ZERO);
  assign recover_s = bus.UD ? ZERO : LAST;

  // Select what the JK inputs do this cycle, in priority order.
  always_comb begin
    mode_s = M_HOLD;
    if (!bus.LD) begin
      mode_s = M_LOAD;
    end else if (bus.EP && bus.ET) begin
      mode_s = ill_s ? M_RECOVER : M_COUNT;
    end else begin
      mode_s = M_HOLD;
    end
  end

  // Toggle terms; at the wrap point, toggle exactly the bits that differ from the wrap target.
  always_comb begin
    toggle_s = ZERO;
    if (bus.UD) begin
      toggle_s = at_last_s ? q_r : up_toggle(q_r);
    end else begin
      toggle_s = at_zero_s ? (q_r ^ LAST) : down_toggle(q_r);
    end
  end

  // Per-bit J/K drive for each mode.
  always_comb begin
    j_s = ZERO;
    k_s = ZERO;
    case (mode_s)
      M_LOAD: begin
        j_s = bus.D;
        k_s = ~bus.D;
      end
      M_COUNT: begin
        j_s = toggle_s;
        k_s = toggle_s;
      end
      M_RECOVER: begin
        j_s = recover_s;
        k_s = ~recover_s;
      end
      default: begin
        j_s = ZERO;
        k_s = ZERO;
      end
    endcase
  end

  assign q_next_s = (j_s & ~q_r) | (~k_s & q_r);

  // State bits; CR clears asynchronously and dominates the clock.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      q_r <= ZERO;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign co_s    = bus.ET & (bus.UD ? at_last_s : at_zero_s);
  assign bus.Q   = q_r;
  assign bus.CO  = co_s;
  assign bus.ILL = ill_s;

endmodule
